// File: rtl/manchester_decoder_pkg.sv
// Shared definitions for the Manchester receive path: FSM states, default
// minimum half-bit period, and the bit polarity shared with the encoder.
// Polarity follows IEEE 802.3: a mid-bit rising edge carries a 1.
package manchester_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  // Smallest half-bit period (in clocks) the windows are sized for
  localparam int MIN_HALF_DEFAULT = 4;

  // Line level after a mid-bit rising edge; the encoder drives the same sense
  localparam logic MANCH_RISE_BIT = 1'b1;

  // Clamp a requested half-bit period up to the legal minimum
  function automatic logic [31:0] clamp_half(input logic [31:0] hp, input logic [31:0] min_hp);
    return (hp < min_hp) ? min_hp : hp;
  endfunction

endpackage

// File: rtl/manchester_decoder_sync_edge.sv
// Synchronises the asynchronous Manchester line and flags level changes.
// Latency: SYNC_STAGES flops to the synchronised level, plus one register
// that presents the level and a rise|fall edge flag together.
module manchester_decoder_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   edge_q;

  // Metastability chain: line enters at bit 0, settled level at the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  // Level and edge registered together so the edge flag and the new level line up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= sync_q[SYNC_STAGES-1];
      edge_q  <= sync_q[SYNC_STAGES-1] ^ level_q;
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester receiver: recovers NRZ bits from mid-bit transitions, one
// data_valid strobe per bit, SYNC_STAGES+2 clocks after the line changes.
// Optional error counter is enabled by defining MANCH_ERR_CNT_EN.
module manchester_decoder
  import manchester_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF    = MIN_HALF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [31:0] half_period,
  input  logic        line_in,
  output logic        data_out,
  output logic        data_valid,
  output logic        locked,
  output logic        code_err
`ifdef MANCH_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  state_e      state_q, state_d;
  logic [31:0] hp_q, hp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        data_q, data_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic        line_lvl;
  logic        line_edge;
  logic        rx_bit;
  logic [33:0] win_lo;
  logic [33:0] win_hi;
  logic [33:0] cnt_ext;
  logic        in_win;
  logic        tmo;

  manchester_decoder_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .line_i (line_in),
    .level_o(line_lvl),
    .edge_o (line_edge)
  );

  // Acceptance window around the next mid-bit edge: 1.5 to 2.5 half periods.
  // 34-bit arithmetic so a huge half_period cannot wrap the window.
  assign win_lo  = {2'b00, hp_q} + {3'b000, hp_q[31:1]};
  assign win_hi  = {1'b0, hp_q, 1'b0} + {3'b000, hp_q[31:1]};
  assign cnt_ext = {2'b00, cnt_q};
  assign in_win  = line_edge && (cnt_ext >= win_lo) && (cnt_ext < win_hi);
  assign tmo     = (cnt_ext >= win_hi);
  assign rx_bit  = (line_lvl == MANCH_RISE_BIT);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: cs low overrides any edge or timeout in the same cycle
  always_comb begin
    state_d = state_q;
    if (!cs) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (line_edge) state_d = ST_ALIGN;
        ST_ALIGN: begin
          if (tmo)         state_d = ST_IDLE;
          else if (in_win) state_d = ST_TRACK;
        end
        ST_TRACK: if (tmo) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath next values; edges before the window are
  // bit-boundary transitions and only let the counter run on
  always_comb begin
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    if (!cs) begin
      cnt_d    = '0;
      data_d   = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (line_edge) hp_d = clamp_half(half_period, 32'(MIN_HALF));
        end
        ST_ALIGN, ST_TRACK: begin
          if (tmo) begin
            cnt_d    = '0;
            locked_d = 1'b0;
            err_d    = (state_q == ST_TRACK);
          end else if (in_win) begin
            cnt_d    = '0;
            valid_d  = 1'b1;
            data_d   = rx_bit;
            locked_d = 1'b1;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
          end
        end
        default: begin
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_q     <= 32'(MIN_HALF);
      cnt_q    <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign code_err   = err_q;

`ifdef MANCH_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of tracking losses; survives cs, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_cnt_q <= '0;
    else if (err_d && (err_cnt_q != '1))   err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_manchester_decoder.sv
// Bench for manchester_decoder: directed scenarios plus randomized streams,
// checked every cycle against a gap-based reference of the decoding rules.
module tb_manchester_decoder;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] half_period = 32'd8;
  logic        line_in = 1'b0;
  logic        data_out;
  logic        data_valid;
  logic        locked;
  logic        code_err;
`ifdef MANCH_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  manchester_decoder #(
    .SYNC_STAGES(S),
    .MIN_HALF   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .half_period(half_period),
    .line_in    (line_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .code_err   (code_err)
`ifdef MANCH_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the history of sampled line levels and the gap (in clocks)
  // since the last accepted edge: accept when LO < gap <= HI, lose lock
  // when the gap exceeds HI.
  logic [7:0]  h = '0;
  int          phase = 0;         // 0 idle, 1 hunting, 2 tracking
  longint      p = 0, ref_p = 0, g = 0, lo = 0, hi = 0, hpm = 4;
  logic        ev;
  logic        m_valid = 0, m_data = 0, m_locked = 0, m_err = 0;
  int          m_errcnt = 0;
  int          m_nvalid = 0, m_nerr = 0;
  longint      m_last_v = 0, m_gap = 0, m_err_p = 0;
  logic [15:0] m_bits = '0;
  int          d_nvalid = 0, d_nerr = 0;

  always @(posedge clk) begin
    p = p + 1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      h        = '0;
      phase    = 0;
      m_data   = 1'b0;
      m_locked = 1'b0;
      m_errcnt = 0;
    end else begin
      h  = {h[6:0], line_in};
      ev = h[S+1] ^ h[S+2];
      if (!cs) begin
        phase    = 0;
        m_data   = 1'b0;
        m_locked = 1'b0;
      end else if (phase == 0) begin
        if (ev) begin
          hpm   = (half_period < 32'd4) ? 64'd4 : 64'(half_period);
          lo    = hpm + hpm / 2;
          hi    = 2 * hpm + hpm / 2;
          ref_p = p;
          phase = 1;
        end
      end else begin
        g = p - ref_p;
        if (g > hi) begin
          if (phase == 2) begin
            m_err   = 1'b1;
            m_nerr++;
            m_err_p = p;
            if (m_errcnt < 65535) m_errcnt++;
          end
          m_locked = 1'b0;
          phase    = 0;
        end else if (ev && g > lo) begin
          m_valid  = 1'b1;
          m_data   = h[S+1];
          m_locked = 1'b1;
          phase    = 2;
          ref_p    = p;
          m_nvalid++;
          m_bits   = {m_bits[14:0], h[S+1]};
          m_gap    = p - m_last_v;
          m_last_v = p;
        end
      end
    end
  end

  // Per-cycle comparison, half a clock after the active edge
  always @(negedge clk) begin
    chk("data_valid", 64'(data_valid), rst ? 64'd0 : 64'(m_valid));
    chk("data_out",   64'(data_out),   rst ? 64'd0 : 64'(m_data));
    chk("locked",     64'(locked),     rst ? 64'd0 : 64'(m_locked));
    chk("code_err",   64'(code_err),   rst ? 64'd0 : 64'(m_err));
`ifdef MANCH_ERR_CNT_EN
    chk("err_count",  64'(err_count),  rst ? 64'd0 : 64'(m_errcnt));
`endif
    if (data_valid === 1'b1) d_nvalid++;
    if (code_err === 1'b1)   d_nerr++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hpe);
    line_in = ~b;
    tick(hpe);
    line_in = b;
    tick(hpe);
  endtask

  task automatic send_byte(input logic [7:0] v, input int hpe);
    for (int i = 7; i >= 0; i--) send_bit(v[i], hpe);
  endtask

  task automatic idle_line();
    line_in = 1'b0;
    tick(150);
  endtask

  task automatic clear_stats();
    m_nvalid = 0;
    m_nerr   = 0;
    m_bits   = '0;
    d_nvalid = 0;
    d_nerr   = 0;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_locked",     64'(locked),     64'd0);
    chk("rst_code_err",   64'(code_err),   64'd0);
    chk("rst_data_out",   64'(data_out),   64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cs = 1'b1;
    tick(5);

    // 1: hp=8, preamble 0x55 then 0xA5
    half_period = 32'd8;
    clear_stats();
    send_byte(8'h55, 8);
    send_byte(8'hA5, 8);
    chk("t1_nbits",    64'(m_nvalid),    64'd14);
    chk("t1_lastbyte", 64'(m_bits[7:0]), 64'hA5);
    chk("t1_spacing",  64'(m_gap),       64'd16);
    chk("t1_no_err",   64'(d_nerr),      64'd0);
    chk("t1_locked",   64'(locked),      64'd1);

    // 2: static line after lock -> one code_err at cnt=20
    tick(40);
    chk("t2_nerr_model", 64'(m_nerr),             64'd1);
    chk("t2_nerr_dut",   64'(d_nerr),             64'd1);
    chk("t2_tmo_delay",  64'(m_err_p - m_last_v), 64'd21);
    chk("t2_unlocked",   64'(locked),             64'd0);
    idle_line();

    // 3: half_period=2 clamps to 4
    half_period = 32'd2;
    clear_stats();
    send_byte(8'h55, 4);
    send_byte(8'h3C, 4);
    chk("t3_nbits",    64'(m_nvalid),    64'd14);
    chk("t3_lastbyte", 64'(m_bits[7:0]), 64'h3C);
    chk("t3_spacing",  64'(m_gap),       64'd8);
    chk("t3_no_err",   64'(d_nerr),      64'd0);
    idle_line();

    // 4: cs low for one clock mid-stream, then relock
    half_period = 32'd8;
    send_byte(8'h55, 8);
    tick(3);
    cs = 1'b0;
    tick(1);
    chk("t4_cs_valid",  64'(data_valid), 64'd0);
    chk("t4_cs_locked", 64'(locked),     64'd0);
    chk("t4_cs_err",    64'(code_err),   64'd0);
    chk("t4_cs_data",   64'(data_out),   64'd0);
    cs = 1'b1;
    tick(4);
    clear_stats();
    send_byte(8'h55, 8);
    send_byte(8'hA5, 8);
    chk("t4_nbits",    64'(m_nvalid),    64'd15);
    chk("t4_lastbyte", 64'(m_bits[7:0]), 64'hA5);
    chk("t4_relocked", 64'(locked),      64'd1);
    idle_line();

    // 5: asynchronous reset mid-bit
    send_byte(8'h55, 8);
    tick(3);
    chk("t5_pre_locked", 64'(locked), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_locked", 64'(locked),     64'd0);
    chk("t5_rst_data",   64'(data_out),   64'd0);
    chk("t5_rst_valid",  64'(data_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    tick(60);
    chk("t5_no_strobe_model", 64'(m_nvalid), 64'd0);
    chk("t5_no_strobe_dut",   64'(d_nvalid), 64'd0);
    chk("t5_no_err",          64'(d_nerr),   64'd0);
    idle_line();

    // Randomized framed streams, with ignored half_period changes and cs glitches
    for (int f = 0; f < 16; f++) begin
      int hp;
      int hpe;
      int nb;
      hp = int'($urandom_range(2, 12));
      half_period = 32'(hp);
      hpe = (hp < 4) ? 4 : hp;
      send_byte(8'h55, hpe);
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) half_period = 32'($urandom_range(1, 40));
        if ($urandom_range(0, 5) == 0) begin
          cs = 1'b0;
          tick(int'($urandom_range(1, 3)));
          cs = 1'b1;
        end
        send_byte(8'($urandom), hpe);
      end
      half_period = 32'(hp);
      idle_line();
    end

    // Free-running random line: gaps sweep across both window edges
    half_period = 32'd8;
    for (int k = 0; k < 400; k++) begin
      line_in = ~line_in;
      tick(int'($urandom_range(1, 24)));
    end
    idle_line();

`ifdef MANCH_ERR_CNT_EN
    // 6: error counter counts timeouts, ignores cs, cleared by rst
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    half_period = 32'd4;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h55, 4);
      idle_line();
    end
    chk("t6_errcnt",       64'(err_count), 64'd3);
    chk("t6_errcnt_model", 64'(m_errcnt),  64'd3);
    cs = 1'b0;
    tick(2);
    cs = 1'b1;
    tick(2);
    chk("t6_errcnt_cs", 64'(err_count), 64'd3);
    rst = 1'b1;
    #1;
    chk("t6_errcnt_rst", 64'(err_count), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
